// File: rtl/cic_decimator_param.sv
// cic_decimator_param: cascaded integrate-and-dump decimator (order 1..3) for a
// 1-bit modulator stream, with a run-time ratio select, scaling to OUT_W bits
// and a 1-deep valid/ready output buffer that has a sticky overrun flag.
//
// Frame phase (derived from the sample counter; there is no separate state register):
//   phase | meaning
//   IDLE  | cnt = 0, waiting for x0; osr_sel is latched when x0 is accepted
//   ACCUM | 0 < cnt < N-1, integrators accumulate on accepted samples
//   DUMP  | edge accepting x(N-1): sums go to hold, integrators/counter clear
module cic_decimator_param #(
  parameter int ORDER    = 2,
  parameter int DEC_LOG2 = 9,
  parameter int OUT_W    = 12,
  parameter int ROUND    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             data_in,
  input  logic [1:0]       osr_sel,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             out_valid,
  output logic             overrun
);

  localparam int IW = ORDER * DEC_LOG2 + 1;
  localparam int CW = DEC_LOG2;
  localparam int SW = ((IW > OUT_W) ? IW : OUT_W) + 1;

  logic [CW-1:0] cnt;
  logic [1:0]    osr_q;
  logic [1:0]    hold_osr;
  logic [IW-1:0] s1, s2, s3;
  logic [IW-1:0] hold;
  logic          dump_q;

  logic [1:0]       osr_eff;
  logic [CW-1:0]    last_cnt;
  logic             last;
  logic [IW-1:0]    s1_n, s2_n, s3_n, result_n;
  logic [OUT_W-1:0] scaled;

  // Right shift needed to bring the full-scale result of a frame down to OUT_W bits.
  function automatic int shift_for(input logic [1:0] osr);
    int l;
    int wf;
    l = DEC_LOG2 - int'(osr);
    if (ORDER == 1)      wf = l + 1;
    else if (ORDER == 2) wf = 2 * l;
    else                 wf = 3 * l - 2;
    return (wf > OUT_W) ? (wf - OUT_W) : 0;
  endfunction

  // Integrator next values and end-of-frame detection; x0 uses the live osr_sel.
  always_comb begin
    osr_eff  = (cnt == '0) ? osr_sel : osr_q;
    last_cnt = {CW{1'b1}} >> osr_eff;
    last     = (cnt == last_cnt);
    s1_n     = s1 + IW'(data_in);
    s2_n     = (ORDER >= 2) ? (s2 + s1_n) : '0;
    s3_n     = (ORDER >= 3) ? (s3 + s2_n) : '0;
    if (ORDER == 1)      result_n = s1_n;
    else if (ORDER == 2) result_n = s2_n;
    else                 result_n = s3_n;
  end

  // Integrators, sample counter, ratio latch and dump into the hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      osr_q    <= '0;
      hold_osr <= '0;
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      hold     <= '0;
      dump_q   <= 1'b0;
    end else begin
      dump_q <= en && last;
      if (en) begin
        if (cnt == '0) osr_q <= osr_sel;
        if (last) begin
          hold     <= result_n;
          hold_osr <= osr_eff;
          cnt      <= '0;
          s1       <= '0;
          s2       <= '0;
          s3       <= '0;
        end else begin
          s1  <= s1_n;
          s2  <= s2_n;
          s3  <= s3_n;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Scale the held frame result: optional half-LSB rounding, shift, saturate.
  always_comb begin
    int sh;
    logic [SW-1:0] rnd;
    logic [SW-1:0] sum_r;
    logic [SW-1:0] shifted;
    sh  = shift_for(hold_osr);
    rnd = '0;
    if (ROUND != 0 && sh > 0) rnd = SW'(1) << (sh - 1);
    sum_r   = SW'(hold) + rnd;
    shifted = sum_r >> sh;
    if (shifted > SW'({OUT_W{1'b1}})) scaled = '1;
    else                             scaled = shifted[OUT_W-1:0];
  end

  // 1-deep output buffer; a load without a consume on a full buffer is an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (dump_q) begin
      data_out  <= scaled;
      out_valid <= 1'b1;
      if (out_valid && !out_ready) overrun <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_decimator_param.sv
// Directed bench for cic_decimator_param: default configuration plus ORDER=1
// and ORDER=3 (truncating and rounding) instances sharing the same stimulus.
module tb_cic_decimator_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       data_in;
  logic [1:0] osr_sel;
  logic       out_ready;

  logic [11:0] d2_out,  d1_out,  d3_out,  d3r_out;
  logic        d2_vld,  d1_vld,  d3_vld,  d3r_vld;
  logic        d2_ovr,  d1_ovr,  d3_ovr,  d3r_ovr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cic_decimator_param #(.ORDER(2), .DEC_LOG2(9), .OUT_W(12), .ROUND(0)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .osr_sel(osr_sel),
    .out_ready(out_ready), .data_out(d2_out), .out_valid(d2_vld), .overrun(d2_ovr));

  cic_decimator_param #(.ORDER(1), .DEC_LOG2(9), .OUT_W(12), .ROUND(0)) dut_o1 (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .osr_sel(osr_sel),
    .out_ready(out_ready), .data_out(d1_out), .out_valid(d1_vld), .overrun(d1_ovr));

  cic_decimator_param #(.ORDER(3), .DEC_LOG2(5), .OUT_W(12), .ROUND(0)) dut_o3 (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .osr_sel(osr_sel),
    .out_ready(out_ready), .data_out(d3_out), .out_valid(d3_vld), .overrun(d3_ovr));

  cic_decimator_param #(.ORDER(3), .DEC_LOG2(5), .OUT_W(12), .ROUND(1)) dut_o3r (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .osr_sel(osr_sel),
    .out_ready(out_ready), .data_out(d3r_out), .out_valid(d3r_vld), .overrun(d3r_ovr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic d);
    en      = e;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  // mode 0: all ones, 1: all zeros, 2: alternating starting with 1
  task automatic feed(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      if (mode == 0)      step(1'b1, 1'b1);
      else if (mode == 1) step(1'b1, 1'b0);
      else                step(1'b1, (i % 2) == 0);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step(1'b0, 1'b0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; data_in = 1'b0; osr_sel = 2'd0; out_ready = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;
    check("rst_data", d2_out, 0);
    check("rst_valid", d2_vld, 0);
    check("rst_overrun", d2_ovr, 0);

    // 512 ones, N=512: 131328 >> 6 = 2052; valid only on the second edge after x511
    feed(512, 0);
    check("lat_not_yet", d2_vld, 0);
    step(1'b0, 1'b0);
    check("ones512_valid", d2_vld, 1);
    check("ones512_data", d2_out, 2052);
    check("ones512_overrun", d2_ovr, 0);
    check("order1_data", d1_out, 512);
    check("order3_data", d3_out, 2992);
    check("order3_round_data", d3r_out, 2992);
    step(1'b0, 1'b0);
    check("hold_while_valid", d2_out, 2052);
    consume();
    check("consume_clears", d2_vld, 0);

    // N=256: 32896 >> 4 = 2056, then all zeros -> 0
    osr_sel = 2'd1;
    feed(256, 0);
    step(1'b0, 1'b0);
    check("osr1_ones_valid", d2_vld, 1);
    check("osr1_ones_data", d2_out, 2056);
    consume();
    feed(256, 1);
    step(1'b0, 1'b0);
    check("osr1_zeros_valid", d2_vld, 1);
    check("osr1_zeros_data", d2_out, 0);
    consume();

    // alternating 1,0 with N=512: s2 = 65792 -> 1028
    osr_sel = 2'd0;
    feed(512, 2);
    step(1'b0, 1'b0);
    check("alt_data", d2_out, 1028);
    consume();

    // two back-to-back frames without consume
    feed(1024, 0);
    check("b2b_first_no_ovr", d2_ovr, 0);
    check("b2b_first_valid", d2_vld, 1);
    step(1'b0, 1'b0);
    check("b2b_overrun", d2_ovr, 1);
    check("b2b_valid", d2_vld, 1);
    check("b2b_data", d2_out, 2052);
    consume();
    check("b2b_consumed", d2_vld, 0);
    check("overrun_sticky", d2_ovr, 1);
    step(1'b0, 1'b0);
    check("overrun_sticky2", d2_ovr, 1);

    // partial frame discarded by reset; en gapped; osr_sel changed mid-frame
    feed(100, 0);
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
    check("rst2_overrun", d2_ovr, 0);
    check("rst2_valid", d2_vld, 0);
    for (int i = 0; i < 512; i++) begin
      osr_sel = (i == 0) ? 2'd0 : 2'd2;
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
    end
    osr_sel = 2'd0;
    check("gap_valid", d2_vld, 1);
    check("gap_data", d2_out, 2052);
    check("gap_no_overrun", d2_ovr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_decimator_param.md
Name: cic_decimator_param

Overview:
- Parametrised successor to the single-bit sinc2 decimation filter in the modulator back-end.
- Accepts the 1-bit modulator stream and performs cascaded integrate-and-dump of order 1–3.
- Decimation ratio is selectable at run time; each scaled unsigned result is delivered over a valid/ready handshake with an overrun flag.
- Sits between the quantiser output and the register/readout interface.

Parameters:
- ORDER, 2, number of cascaded integrators (1, 2 or 3).
- DEC_LOG2, 9, log2 of the maximum decimation ratio (must be >= 5).
- OUT_W, 12, width of data_out.
- ROUND, 0: 0 truncates on scaling; 1 adds half an LSB before the shift.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, sample strobe; data_in is accepted only on edges where en=1.
- data_in, input, 1, modulator bit (0 or 1, unsigned).
- osr_sel, input, 2, ratio select: N = 2^(DEC_LOG2-osr_sel), L = DEC_LOG2-osr_sel.
- out_ready, input, 1, consumer ready.
- data_out, output, OUT_W, scaled filter result.
- out_valid, output, 1, data_out holds an unconsumed result.
- overrun, output, 1, sticky flag: a result was overwritten before it was consumed.

Behaviour:
- Reset: clk edge with rst=1 clears integrators, sample counter, latched ratio, data_out, out_valid and overrun to 0.
  - rst has priority over all other inputs.
  - A partial frame is discarded; the frame restarts at the next accepted sample.
- Frame: N accepted samples x0..x(N-1).
  - s1 = running sum of x.
  - s(k) = running sum of s(k-1).
  - Frame result is s(ORDER) after x(N-1) is included. All-ones values: ORDER1 = N; ORDER2 = N(N+1)/2; ORDER3 = N(N+1)(N+2)/6.
- Ratio latch:
  - osr_sel is sampled on the edge accepting x0 (counter = 0) and held for the whole frame.
  - osr_sel changes mid-frame have no effect until the next frame.
- Internal width: integrators are ORDER*DEC_LOG2+1 bits unsigned and never wrap.
- Scaling:
  - Full-scale width W_full = L+1 (ORDER1), 2L (ORDER2), 3L-2 (ORDER3).
  - SHIFT = max(0, W_full-OUT_W).
  - data_out = min((s + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0)) >> SHIFT, 2^OUT_W-1).
- Edge E (the edge accepting x(N-1)): final sums, including x(N-1), go to a hold register, and all integrators and the counter clear on the same edge.
  - The next frame's x0 may be accepted at E+1 with no lost sample, so back-to-back frames are supported with en held high.
- Edge E+1: scaled value loads into data_out and out_valid is set.
  - Latency: out_valid is high in the second cycle after the last sample edge.
- en=0: integrators and counter hold; gaps of any length are allowed mid-frame.
- Handshake:
  - Consume occurs on an edge with out_valid=1 and out_ready=1, and clears out_valid unless a new result loads on the same edge.
  - data_out holds its value while out_valid=1.
  - New result while out_valid=1 and no consume on that edge: data_out is overwritten, out_valid stays 1, overrun is set.
  - New result and consume on the same edge: the new value loads, out_valid stays 1, overrun is unchanged.
  - overrun clears only on rst.
- No state machine beyond the counter/frame phase: IDLE (counter = 0) -> ACCUM -> DUMP (edge E) -> IDLE or ACCUM (if en).
  - The output stage is a separate 1-deep buffer.

Test Plan:
- Defaults, osr_sel=0, 512 ones with en=1 continuous -> data_out=2052 (131328>>6), out_valid rises 2 cycles after the last sample, overrun=0.
- osr_sel=1 (N=256, SHIFT=4), 256 ones -> 32896>>4 = 2056. Same run with 256 zeros -> 0.
- osr_sel=0, alternating 1,0 starting with 1 -> s2=65792, data_out=1028.
- out_ready=0, two back-to-back all-ones frames -> second out_valid edge sets overrun=1, data_out=2052, no sample dropped.
  - Then out_ready=1 for one cycle -> out_valid=0; overrun stays 1 until rst.
- rst asserted after 100 accepted samples, then 512 ones with en toggling every cycle -> single result 2052; osr_sel toggled mid-frame has no effect.
- ORDER=1, OUT_W=12 -> 512 ones gives 512. ORDER=3, DEC_LOG2=5, N=32 -> 5984>>1 = 2992; with ROUND=1 -> 2992.
